// File: rtl/wb_stage.sv
// Write-back/commit stage: latches one MEM instruction, resolves exceptions/ERTN, drives GPR/CSR commit and pipeline flush.
// Optional golden-trace outputs are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_vaddr,
    input  logic [31:0] ms_result,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [4:0]  ms_ex,
    input  logic        ms_ertn,
    input  logic        ms_csr_we,
    input  logic        ms_csr_rd,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        has_int,
    input  logic [31:0] csr_rvalue,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ex_era,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic        wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    output logic        ws_flush,
    output logic [31:0] ws_flush_target
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    logic        ws_ready_go;
    logic        ws_valid_q, ws_valid_d;
    logic        flush_block_q, flush_block_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] result_q, result_d;
    logic        gr_we_q, gr_we_d;
    logic [4:0]  dest_q, dest_d;
    logic [4:0]  ex_q, ex_d;
    logic        ertn_q, ertn_d;
    logic        csr_we_q, csr_we_d;
    logic        csr_rd_q, csr_rd_d;
    logic [13:0] csr_num_q, csr_num_d;
    logic [31:0] csr_wmask_q, csr_wmask_d;
    logic [31:0] csr_wvalue_q, csr_wvalue_d;

    always_comb begin
        ws_ready_go   = 1'b1;
        ws_allowin    = flush_block_q | ~ws_valid_q | ws_ready_go;
        pc_d          = pc_q;
        vaddr_d       = vaddr_q;
        result_d      = result_q;
        gr_we_d       = gr_we_q;
        dest_d        = dest_q;
        ex_d          = ex_q;
        ertn_d        = ertn_q;
        csr_we_d      = csr_we_q;
        csr_rd_d      = csr_rd_q;
        csr_num_d     = csr_num_q;
        csr_wmask_d   = csr_wmask_q;
        csr_wvalue_d  = csr_wvalue_q;
        ws_valid_d    = ws_valid_q;
        flush_block_d = ws_flush;
        if (ms_to_ws_valid && ws_allowin) begin
            pc_d         = ms_pc;
            vaddr_d      = ms_vaddr;
            result_d     = ms_result;
            gr_we_d      = ms_gr_we;
            dest_d       = ms_dest;
            ex_d         = ms_ex;
            ertn_d       = ms_ertn;
            csr_we_d     = ms_csr_we;
            csr_rd_d     = ms_csr_rd;
            csr_num_d    = ms_csr_num;
            csr_wmask_d  = ms_csr_wmask;
            csr_wvalue_d = ms_csr_wvalue;
        end
        // The instruction already in flight from MEM when a flush fires is dropped.
        if (ws_flush || flush_block_q) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q    <= 1'b0;
            flush_block_q <= 1'b0;
            pc_q          <= 32'h0;
            vaddr_q       <= 32'h0;
            result_q      <= 32'h0;
            gr_we_q       <= 1'b0;
            dest_q        <= 5'h0;
            ex_q          <= 5'h0;
            ertn_q        <= 1'b0;
            csr_we_q      <= 1'b0;
            csr_rd_q      <= 1'b0;
            csr_num_q     <= 14'h0;
            csr_wmask_q   <= 32'h0;
            csr_wvalue_q  <= 32'h0;
        end else begin
            ws_valid_q    <= ws_valid_d;
            flush_block_q <= flush_block_d;
            pc_q          <= pc_d;
            vaddr_q       <= vaddr_d;
            result_q      <= result_d;
            gr_we_q       <= gr_we_d;
            dest_q        <= dest_d;
            ex_q          <= ex_d;
            ertn_q        <= ertn_d;
            csr_we_q      <= csr_we_d;
            csr_rd_q      <= csr_rd_d;
            csr_num_q     <= csr_num_d;
            csr_wmask_q   <= csr_wmask_d;
            csr_wvalue_q  <= csr_wvalue_d;
        end
    end

    always_comb begin
        wb_ex       = ws_valid_q & (has_int | (|ex_q));
        wb_ecode    = 6'h00;
        wb_esubcode = 1'b0;
        // Priority INT > ADEF > INE > SYS > BRK > ALE; ex_q is {ale, brk, sys, ine, adef}.
        if (wb_ex) begin
            if (has_int)       wb_ecode = 6'h00;
            else if (ex_q[0])  wb_ecode = 6'h08;
            else if (ex_q[1])  wb_ecode = 6'h0D;
            else if (ex_q[2])  wb_ecode = 6'h0B;
            else if (ex_q[3])  wb_ecode = 6'h0C;
            else               wb_ecode = 6'h09;
        end
        ertn_flush      = ws_valid_q & ertn_q & ~wb_ex;
        ws_flush        = wb_ex | ertn_flush;
        ws_flush_target = wb_ex ? ex_entry : (ertn_flush ? ex_era : 32'h0);
        rf_we           = ws_valid_q & gr_we_q & ~wb_ex;
        rf_waddr        = dest_q;
        rf_wdata        = csr_rd_q ? csr_rvalue : result_q;
        csr_we          = ws_valid_q & csr_we_q & ~wb_ex;
        csr_num         = csr_num_q;
        csr_wmask       = csr_wmask_q;
        csr_wvalue      = csr_wvalue_q;
        wb_pc           = pc_q;
        wb_vaddr        = vaddr_q;
    end

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
